// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: data width, memory access ops and dmem arbiter state/count sizing.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int DMEM_ARB_CNT_W = 8;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_t;

  typedef enum logic {
    ARB_PIPE = 1'b0,
    ARB_LD   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Loader starvation tracker: counts consecutive denied loader cycles and raises
// force_ld once the loader has waited MAX_WAIT cycles.
import riscv_pkg::*;

module dmem_arb_starve_cnt #(
  parameter int MAX_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld_req_valid,
  input  logic                      grant_ld,
  output logic [DMEM_ARB_CNT_W-1:0] wait_cnt,
  output logic                      force_ld
);

  localparam logic [DMEM_ARB_CNT_W-1:0] MAX_WAIT_C = DMEM_ARB_CNT_W'(MAX_WAIT);

  // Saturates at all-ones so a long stall can never wrap back below MAX_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!ld_req_valid || grant_ld) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign force_ld = (wait_cnt >= MAX_WAIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-way dmem arbiter: the pipeline MEM stage has default priority, the loader
// gets bounded bursts and a starvation-forced grant.
import riscv_pkg::*;

module dmem_arbiter #(
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_req_valid,
  input  logic            pipe_wr_en,
  input  logic [XLEN-1:0] pipe_addr,
  input  logic [XLEN-1:0] pipe_wdata,
  input  mem_op_t         pipe_mem_op,
  output logic            pipe_stall,
  output logic [XLEN-1:0] pipe_rdata,
  input  logic            ld_req_valid,
  output logic            ld_req_ready,
  input  logic            ld_wr_en,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [XLEN-1:0] ld_wdata,
  input  mem_op_t         ld_mem_op,
  output logic            ld_rsp_valid,
  output logic [XLEN-1:0] ld_rsp_data,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_wr_en,
  output logic            dmem_rd_en,
  output mem_op_t         dmem_mem_op,
  input  logic [XLEN-1:0] dmem_rdata
);

  localparam logic [DMEM_ARB_CNT_W-1:0] BURST_LAST = DMEM_ARB_CNT_W'(BURST_MAX - 1);

  arb_state_t                state;
  logic [DMEM_ARB_CNT_W-1:0] beat_cnt;
  logic [DMEM_ARB_CNT_W-1:0] wait_cnt;
  logic                      force_ld;
  logic                      grant_ld;
  logic                      grant_pipe;

  dmem_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_cnt (
    .clk         (clk),
    .reset       (reset),
    .ld_req_valid(ld_req_valid),
    .grant_ld    (grant_ld),
    .wait_cnt    (wait_cnt),
    .force_ld    (force_ld)
  );

  always_comb begin
    grant_ld   = 1'b0;
    grant_pipe = 1'b0;
    if (state == ARB_PIPE) begin
      grant_ld   = ld_req_valid && (!pipe_req_valid || force_ld);
      grant_pipe = pipe_req_valid && !grant_ld;
    end else begin
      grant_ld   = ld_req_valid;
      grant_pipe = pipe_req_valid && !ld_req_valid;
    end
  end

  assign ld_req_ready = grant_ld;
  assign pipe_stall   = pipe_req_valid && !grant_pipe;
  assign pipe_rdata   = grant_pipe ? dmem_rdata : '0;

  always_comb begin
    dmem_addr   = '0;
    dmem_wdata  = '0;
    dmem_wr_en  = 1'b0;
    dmem_rd_en  = 1'b0;
    dmem_mem_op = MEM_B;
    if (grant_ld) begin
      dmem_addr   = ld_addr;
      dmem_wdata  = ld_wdata;
      dmem_wr_en  = ld_wr_en;
      dmem_rd_en  = !ld_wr_en;
      dmem_mem_op = ld_mem_op;
    end else if (grant_pipe) begin
      dmem_addr   = pipe_addr;
      dmem_wdata  = pipe_wdata;
      dmem_wr_en  = pipe_wr_en;
      dmem_rd_en  = !pipe_wr_en;
      dmem_mem_op = pipe_mem_op;
    end
  end

  // The entry beat is granted from ARB_PIPE, so the burst ends once the beat
  // being granted in ARB_LD is the BURST_MAX-th one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_PIPE;
      beat_cnt <= '0;
    end else if (state == ARB_PIPE) begin
      if (grant_ld) begin
        beat_cnt <= DMEM_ARB_CNT_W'(1);
        state    <= (BURST_MAX == 1) ? ARB_PIPE : ARB_LD;
      end
    end else begin
      if (!ld_req_valid) begin
        state <= ARB_PIPE;
      end else if (beat_cnt >= BURST_LAST) begin
        beat_cnt <= beat_cnt + 1'b1;
        state    <= ARB_PIPE;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_rsp_valid <= 1'b0;
      ld_rsp_data  <= '0;
    end else begin
      ld_rsp_valid <= grant_ld && !ld_wr_en;
      if (grant_ld && !ld_wr_en) begin
        ld_rsp_data <= dmem_rdata;
      end
    end
  end

endmodule
